trace_checker: RTL
==================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning DUT-trace buffer entries (power of two, >=2).
REQ-002 SHALL have parameter END_PC, default 32'h0000_0FFC, meaning PC whose matched compare ends the test.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning max RUN cycles without a compare.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wb_have_inst  input  1  DUT write-back slot holds a retired instruction.
REQ-007 wb_pc  input  32  PC of retired instruction.
REQ-008 wb_ena  input  1  register-file write enable.
REQ-009 wb_reg  input  5  destination register.
REQ-010 wb_value  input  32  written value.
REQ-011 golden_valid  input  1  golden entry offered.
REQ-012 golden_ready  output  1  golden entry consumed this cycle.
REQ-013 golden_pc / golden_ena / golden_reg / golden_value  input  32/1/5/32  expected entry fields.
REQ-014 done  output  1  test passed (sticky).
REQ-015 fail  output  1  test failed (sticky).
REQ-016 err_code  output  3  0 none, 1 pc, 2 ena, 3 reg, 4 value, 5 overflow, 6 timeout.
REQ-017 err_pc  output  32  DUT PC of the failing entry (0 for overflow/timeout).
REQ-018 inst_cnt  output  32  count of matched compares.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE, FAIL; IDLE->RUN on first push; RUN->DONE on matched compare with pc==END_PC; RUN->FAIL on any error; DONE and FAIL absorbing until reset.
REQ-020 SHALL push {wb_pc, wb_ena, wb_reg, wb_value} into FIFO on each rising edge with wb_have_inst=1 in IDLE or RUN; pushes ignored in DONE/FAIL.
REQ-021 SHALL drive golden_ready=1 combinationally iff state==RUN and FIFO non-empty; transfer occurs on edge with golden_valid&&golden_ready, popping one FIFO entry.
REQ-022 SHALL compare in priority order pc, ena, reg, value; reg and value checked only when ena=1 and reg!=0; ena=1 with reg=0 on either side is treated as ena=0.
REQ-023 SHALL, on mismatch, set fail=1, err_code, err_pc=DUT pc on the transfer edge (1-cycle latency from handshake to fail visible).
REQ-024 SHALL increment inst_cnt on each matched transfer, saturating at 32'hFFFF_FFFF.
REQ-025 SHALL allow simultaneous push and pop when FIFO full without error.
REQ-026 SHALL, on push while full with no pop, enter FAIL with err_code=5; the pushed entry is dropped.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH with one extra bit distinguishing full from empty.
REQ-028 SHALL never assert done and fail simultaneously; first event wins, later errors ignored.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, FIFO empty, done=0, fail=0, err_code=0, err_pc=0, inst_cnt=0, golden_ready=0, timeout counter=0; assertion mid-test discards all buffered entries.

Configuration
REQ-030 With TRACE_CHECKER_TIMEOUT_EN defined SHALL count RUN cycles since last transfer, clear on transfer, and enter FAIL with err_code=6 when count reaches TIMEOUT_CYC.
REQ-031 Without TRACE_CHECKER_TIMEOUT_EN SHALL contain no timeout counter and never produce err_code=6.

Structure
REQ-032 SHALL place err_code constants, state enum and trace-entry struct typedef (pc, ena, reg, value; 70 bits) in shared package trace_pkg.
REQ-033 SHALL instantiate one sub-module trace_fifo (synchronous FIFO, parameterised depth/width, full/empty flags).

Verification
REQ-034 Three matching entries, last pc=END_PC, golden_valid held 1 -> done=1 one cycle after third transfer, inst_cnt=3, fail=0.
REQ-035 DUT wb_value=32'h5 vs golden 32'h6, reg=x3, ena=1 -> fail=1, err_code=4, err_pc=DUT pc, inst_cnt unchanged.
REQ-036 DUT ena=1 reg=x0 vs golden ena=0, same pc -> match, inst_cnt increments.
REQ-037 golden_valid=0, FIFO_DEPTH+1 consecutive pushes -> fail=1, err_code=5 on the fifth push edge (depth 4).
REQ-038 With macro: RUN, golden_valid=0 for TIMEOUT_CYC cycles -> fail=1, err_code=6; without macro -> no fail after 2*TIMEOUT_CYC.
REQ-039 rst_n pulsed low mid-RUN with 2 entries buffered -> all outputs 0, golden_ready=0 next cycle, subsequent clean trace reaches done.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace checker: FSM state encoding, trace-entry layout,
// error codes and the entry comparison rule.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // 70-bit retired-instruction record; "rd" holds the destination register.
    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rd;
        logic [31:0] value;
    } trace_entry_t;

    localparam int unsigned TRACE_W = $bits(trace_entry_t);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_PC       = 3'd1;
    localparam logic [2:0] ERR_ENA      = 3'd2;
    localparam logic [2:0] ERR_REG      = 3'd3;
    localparam logic [2:0] ERR_VALUE    = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

    // Priority pc > ena > reg > value. A write to x0 is architecturally a
    // no-op, so ena with rd==0 is folded to "no write" on both sides.
    function automatic logic [2:0] compare_entry(input trace_entry_t dut,
                                                 input trace_entry_t gold);
        logic dut_wr;
        logic gold_wr;
        logic [2:0] code;
        dut_wr  = dut.ena  && (dut.rd  != 5'd0);
        gold_wr = gold.ena && (gold.rd != 5'd0);
        code    = ERR_NONE;
        if (dut.pc != gold.pc) begin
            code = ERR_PC;
        end else if (dut_wr != gold_wr) begin
            code = ERR_ENA;
        end else if (dut_wr && (dut.rd != gold.rd)) begin
            code = ERR_REG;
        end else if (dut_wr && (dut.value != gold.value)) begin
            code = ERR_VALUE;
        end
        return code;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO buffering DUT write-back entries until the golden model
// catches up. Pointers carry one extra wrap bit to tell full from empty.
// Storage is not reset; only the pointers are.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer and storage values for this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, data only.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/trace_checker.sv
// Lock-step trace checker: buffers DUT retirements, compares them in order
// against golden entries, and latches pass/fail with a sticky error record.
// Optional macro TRACE_CHECKER_TIMEOUT_EN adds a RUN-state stall timeout.
module trace_checker
    import trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] END_PC      = 32'h0000_0FFC,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_have_inst,
    input  logic [31:0] wb_pc,
    input  logic        wb_ena,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_value,
    input  logic        golden_valid,
    output logic        golden_ready,
    input  logic [31:0] golden_pc,
    input  logic        golden_ena,
    input  logic [4:0]  golden_reg,
    input  logic [31:0] golden_value,
    output logic        done,
    output logic        fail,
    output logic [2:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] inst_cnt
);

    state_t       state_q, state_d;
    logic [2:0]   err_code_q, err_code_d;
    logic [31:0]  err_pc_q, err_pc_d;
    logic [31:0]  inst_cnt_q, inst_cnt_d;
    trace_entry_t wb_entry;
    trace_entry_t gold_entry;
    trace_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push_req;
    logic         fifo_push;
    logic         xfer;
    logic         tmo_hit;
    logic [2:0]   cmp_code;

    assign wb_entry   = '{pc: wb_pc, ena: wb_ena, rd: wb_reg, value: wb_value};
    assign gold_entry = '{pc: golden_pc, ena: golden_ena, rd: golden_reg, value: golden_value};

    assign push_req     = wb_have_inst && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign golden_ready = (state_q == ST_RUN) && !fifo_empty;
    assign xfer         = golden_valid && golden_ready;
    // A push into a full buffer is dropped unless a pop frees a slot.
    assign fifo_push    = push_req && (!fifo_full || xfer);

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (xfer),
        .wdata (wb_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef TRACE_CHECKER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Count RUN cycles since the last transfer; any other state holds zero.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((state_q == ST_RUN) && !xfer) begin
            tmo_d   = tmo_q + 32'd1;
            tmo_hit = (tmo_d == 32'(TIMEOUT_CYC));
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
    assign tmo_hit        = 1'b0;
`endif

    // Next state and sticky result; the first terminal event wins.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        inst_cnt_d = inst_cnt_q;
        cmp_code   = compare_entry(head, gold_entry);
        case (state_q)
            ST_IDLE: begin
                if (push_req) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer) begin
                    if (cmp_code != ERR_NONE) begin
                        state_d    = ST_FAIL;
                        err_code_d = cmp_code;
                        err_pc_d   = head.pc;
                    end else begin
                        if (inst_cnt_q != 32'hFFFF_FFFF) inst_cnt_d = inst_cnt_q + 32'd1;
                        if (head.pc == END_PC) state_d = ST_DONE;
                    end
                end else if (push_req && fifo_full) begin
                    state_d    = ST_FAIL;
                    err_code_d = ERR_OVERFLOW;
                    err_pc_d   = '0;
                end else if (tmo_hit) begin
                    state_d    = ST_FAIL;
                    err_code_d = ERR_TIMEOUT;
                    err_pc_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            err_pc_q   <= '0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign done     = (state_q == ST_DONE);
    assign fail     = (state_q == ST_FAIL);
    assign err_code = err_code_q;
    assign err_pc   = err_pc_q;
    assign inst_cnt = inst_cnt_q;

endmodule
